// File: rtl/fetch_stage_if.sv
// Fetch-side bundle: imem request/response channel plus the if_id outputs consumed by decode.
// master = fetch stage; slave = memory/decode side.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        data_hazard;
  logic        pipe_flush;
  logic [31:0] jump_target;
  logic [31:0] if_id__pc;
  logic [31:0] if_id__ins;

  modport master (
    output imem_req_valid, imem_req_addr, if_id__pc, if_id__ins,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, data_hazard, pipe_flush, jump_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_id__pc, if_id__ins,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, data_hazard, pipe_flush, jump_target
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem requests, response FIFO, if_id register; FETCH_PERF_EN adds perf counters.
// Latency accept->rsp->FIFO->if_id (no bypass); requests stall when outstanding+buffered reaches FIFO_DEPTH.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fs
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_hazard_cycles,
  output logic [31:0]   perf_discards
`endif
);
  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] BUBBLE_PC = 32'hffff_ffff;
  localparam logic [31:0] NOP_INS   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_ent_t;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] tag_count;
  logic [CW:0]   in_use;
  logic [31:0]   tag_head;
  fetch_ent_t    push_ent;
  fetch_ent_t    head;
  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  logic [31:0]   if_id_pc_q;
  logic [31:0]   if_id_ins_q;

  assign in_use             = {1'b0, outstanding} + {1'b0, fifo_count};
  assign fs.imem_req_valid  = !rst && !fs.pipe_flush && (in_use < (CW + 1)'(FIFO_DEPTH));
  assign fs.imem_req_addr   = pc;
  assign req_fire           = fs.imem_req_valid && fs.imem_req_ready;
  assign outstanding_nxt    = outstanding + CW'(req_fire) - CW'(fs.imem_rsp_valid);

  // Responses owed to a pre-flush stream are dropped without touching the tag FIFO,
  // which the flush already emptied; only live requests have tags queued.
  assign rsp_keep = fs.imem_rsp_valid && !fs.pipe_flush && (discard == '0) && (tag_count != '0);
  assign pop      = !fs.pipe_flush && !fs.data_hazard && (fifo_count != '0);
  assign push_ent = '{pc: tag_head, ins: fs.imem_rsp_data};

  assign fs.if_id__pc  = if_id_pc_q;
  assign fs.if_id__ins = if_id_ins_q;

  fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (fs.pipe_flush),
    .push     (req_fire),
    .push_dat (pc),
    .pop      (rsp_keep),
    .pop_dat  (tag_head),
    .count    (tag_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_ent_t)), .DEPTH(FIFO_DEPTH)) u_ins_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (fs.pipe_flush),
    .push     (rsp_keep),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      if_id_pc_q  <= BUBBLE_PC;
      if_id_ins_q <= NOP_INS;
    end else begin
      outstanding <= outstanding_nxt;
      if (fs.pipe_flush) begin
        pc      <= fs.jump_target;
        discard <= outstanding_nxt;
      end else begin
        if (req_fire)
          pc <= pc + 32'd4;
        if (fs.imem_rsp_valid && (discard != '0))
          discard <= discard - CW'(1);
      end

      if (fs.pipe_flush) begin
        if_id_pc_q  <= BUBBLE_PC;
        if_id_ins_q <= NOP_INS;
      end else if (fs.data_hazard) begin
        if_id_pc_q  <= if_id_pc_q;
        if_id_ins_q <= if_id_ins_q;
      end else if (fifo_count != '0) begin
        if_id_pc_q  <= head.pc;
        if_id_ins_q <= head.ins;
      end else begin
        if_id_pc_q  <= BUBBLE_PC;
        if_id_ins_q <= NOP_INS;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hazard_cycles <= '0;
      perf_discards      <= '0;
    end else begin
      if (fs.data_hazard && !fs.pipe_flush)
        perf_hazard_cycles <= perf_hazard_cycles + 32'd1;
      if (fs.imem_rsp_valid && (fs.pipe_flush || (discard != '0)))
        perf_discards <= perf_discards + 32'd1;
    end
  end
`endif
endmodule

// Generic synchronous FIFO, show-ahead head; clr empties it. Caller never pushes a full
// FIFO without popping in the same cycle, nor pops an empty one.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !rst && !clr)
      mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
